// File: rtl/dbg_mon_pkg.sv
// Shared types for the debug store monitor: FSM states, default match constants, FIFO entry layout.
// No logic, so no latency.
// No backpressure; the entry layout gains a timestamp field when DBG_MON_TIMESTAMP_EN is defined.
package dbg_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } mon_state_e;

  localparam logic [11:0] DEF_REGION  = 12'h001;
  localparam logic [31:0] DEF_HALT_PC = 32'h0000_0064;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
`ifdef DBG_MON_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } mon_entry_t;

  localparam int ENTRY_W = $bits(mon_entry_t);

endpackage

// File: rtl/dbg_sync_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head; head data reads as zero when empty.
// A push at edge N is visible at the head in the cycle after N when the FIFO was empty.
// A push is refused when full, unless a pop happens in the same cycle; the head holds until it is popped.
module dbg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (do_pop && !do_push) level_d = level_q - LW'(1);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head output is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/dbg_store_monitor.sv
// Captures core stores into the debug region, queues them and drains over valid/ready; flags HALT at end of run.
// A captured store reaches the head one cycle after its push edge when the queue was empty.
// OUT_* hold while OUT_READY is low; stores arriving at a full queue are dropped and counted. Macro DBG_MON_TIMESTAMP_EN adds OUT_TIME.
module dbg_store_monitor
  import dbg_mon_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [11:0] REGION  = DEF_REGION,
  parameter logic [31:0] HALT_PC = DEF_HALT_PC,
  parameter int          GUARD   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [31:0]            PC,
  input  logic                   ST_EN,
  input  logic [31:0]            ST_ADDR,
  input  logic [31:0]            ST_DATA,
  input  logic [3:0]             ST_BE,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [31:0]            OUT_ADDR,
  output logic [31:0]            OUT_DATA,
  output logic [3:0]             OUT_BE,
`ifdef DBG_MON_TIMESTAMP_EN
  output logic [31:0]            OUT_TIME,
`endif
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic [15:0]            DROP_CNT,
  output logic                   HALT
);
  // Sized so GUARD=0 still yields a legal one-bit counter.
  localparam int GW = $clog2(GUARD + 2);

  mon_state_e    state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [15:0]   drop_q, drop_d;
  logic          match, push, pop, full, empty;
  mon_entry_t    in_entry, head_entry;

  assign match = ST_EN && (ST_ADDR[31:20] == REGION) && (state_q != ST_HALTED);
  assign pop   = OUT_VALID && OUT_READY;
  assign push  = match && (!full || pop);

`ifdef DBG_MON_TIMESTAMP_EN
  logic [31:0] time_q, time_d;

  // Free-running cycle counter stamped into each entry at its push edge.
  always_comb begin
    time_d = time_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge CLK) begin
    if (RST) time_q <= '0;
    else     time_q <= time_d;
  end

  assign in_entry = '{addr: ST_ADDR, data: ST_DATA, be: ST_BE, ts: time_q};
  assign OUT_TIME = head_entry.ts;
`else
  assign in_entry = '{addr: ST_ADDR, data: ST_DATA, be: ST_BE};
`endif

  dbg_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (push),
    .push_dat (in_entry),
    .pop      (pop),
    .pop_dat  (head_entry),
    .full     (full),
    .empty    (empty),
    .level    (LEVEL)
  );

  assign OUT_VALID = !empty;
  assign OUT_ADDR  = head_entry.addr;
  assign OUT_DATA  = head_entry.data;
  assign OUT_BE    = head_entry.be;
  assign DROP_CNT  = drop_q;
  assign HALT      = (state_q == ST_HALTED);

  // Run/drain/halt sequencing plus the saturating drop counter.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    drop_d  = drop_q;
    if (match && !push && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    case (state_q)
      ST_RUN: begin
        if (PC == HALT_PC) begin
          state_d = ST_DRAIN;
          guard_d = GW'(GUARD);
        end
      end
      ST_DRAIN: begin
        // Keep capturing while stores still in the pipeline can land.
        if (guard_q != '0)                   guard_d = guard_q - GW'(1);
        else if ((LEVEL == '0) && !push)     state_d = ST_HALTED;
      end
      default: state_d = state_q;
    endcase
  end

  // State, guard and drop registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      guard_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_dbg_store_monitor.sv
// Directed bench for dbg_store_monitor: vector table for single-cycle behaviour, hand sequences for multi-cycle cases.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Covers overflow, full-with-pop, halt sequencing and mid-drain reset.
module tb_dbg_store_monitor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic        ST_EN;
  logic [31:0] ST_ADDR, ST_DATA;
  logic [3:0]  ST_BE;
  logic        OUT_VALID, OUT_READY;
  logic [31:0] OUT_ADDR, OUT_DATA;
  logic [3:0]  OUT_BE;
  logic [4:0]  LEVEL;
  logic [15:0] DROP_CNT;
  logic        HALT;
`ifdef DBG_MON_TIMESTAMP_EN
  logic [31:0] OUT_TIME;
`endif

  int checks = 0;
  int errors = 0;

  dbg_store_monitor dut (
    .CLK (CLK), .RST (RST), .PC (PC),
    .ST_EN (ST_EN), .ST_ADDR (ST_ADDR), .ST_DATA (ST_DATA), .ST_BE (ST_BE),
    .OUT_VALID (OUT_VALID), .OUT_READY (OUT_READY),
    .OUT_ADDR (OUT_ADDR), .OUT_DATA (OUT_DATA), .OUT_BE (OUT_BE),
`ifdef DBG_MON_TIMESTAMP_EN
    .OUT_TIME (OUT_TIME),
`endif
    .LEVEL (LEVEL), .DROP_CNT (DROP_CNT), .HALT (HALT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        st_en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        rdy;
    logic        exp_vld;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [4:0]  exp_level;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    ST_EN = 1'b1; ST_ADDR = a; ST_DATA = d; ST_BE = b;
    step();
    ST_EN = 1'b0;
  endtask

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  initial begin
    RST = 1'b1; PC = 32'h0; ST_EN = 1'b0; ST_ADDR = '0; ST_DATA = '0; ST_BE = '0; OUT_READY = 1'b0;
    step();
    step();
    RST = 1'b0;
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_addr",  OUT_ADDR, 32'd0);
    chk("rst_data",  OUT_DATA, 32'd0);
    chk("rst_be",    32'(OUT_BE), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_drop",  32'(DROP_CNT), 32'd0);
    chk("rst_halt",  32'(HALT), 32'd0);

    // Each row: inputs held across one edge, expected outputs just after it.
    vecs[0] = '{1'b1, 32'h0010_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 32'h0010_0004, 32'hDEAD_BEEF, 4'hF, 5'd1, 16'd0};
    vecs[1] = '{1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b0, 32'h0,         32'h0,         4'h0, 5'd0, 16'd0};
    vecs[2] = '{1'b1, 32'h0020_0000, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 32'h0,         32'h0,         4'h0, 5'd0, 16'd0};
    vecs[3] = '{1'b1, 32'h0010_0008, 32'h1111_1111, 4'h3, 1'b0, 1'b1, 32'h0010_0008, 32'h1111_1111, 4'h3, 5'd1, 16'd0};
    vecs[4] = '{1'b1, 32'h0010_000C, 32'h2222_2222, 4'hC, 1'b0, 1'b1, 32'h0010_0008, 32'h1111_1111, 4'h3, 5'd2, 16'd0};
    vecs[5] = '{1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b1, 32'h0010_000C, 32'h2222_2222, 4'hC, 5'd1, 16'd0};
    vecs[6] = '{1'b1, 32'h0010_0010, 32'h3333_3333, 4'h1, 1'b1, 1'b1, 32'h0010_0010, 32'h3333_3333, 4'h1, 5'd1, 16'd0};
    vecs[7] = '{1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b0, 32'h0,         32'h0,         4'h0, 5'd0, 16'd0};

    for (int i = 0; i < 8; i++) begin
      ST_EN = vecs[i].st_en; ST_ADDR = vecs[i].addr; ST_DATA = vecs[i].data; ST_BE = vecs[i].be;
      OUT_READY = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(OUT_VALID), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_addr", i),  OUT_ADDR, vecs[i].exp_addr);
      chk($sformatf("vec%0d_data", i),  OUT_DATA, vecs[i].exp_data);
      chk($sformatf("vec%0d_be", i),    32'(OUT_BE), 32'(vecs[i].exp_be));
      chk($sformatf("vec%0d_level", i), 32'(LEVEL), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d_drop", i),  32'(DROP_CNT), 32'(vecs[i].exp_drop));
    end
    ST_EN = 1'b0;

    // Overflow: 18 stores into a 16-deep queue with the consumer stalled.
    OUT_READY = 1'b0;
    for (int i = 0; i < 18; i++) begin
      store(32'h0010_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
      if (i < 16) begin
        exp_addr_q.push_back(32'h0010_0000 + 32'(i * 4));
        exp_data_q.push_back(32'hA000_0000 + 32'(i));
      end
    end
    chk("ovf_level", 32'(LEVEL), 32'd16);
    chk("ovf_drop",  32'(DROP_CNT), 32'd2);

    // Full plus simultaneous pop: the new store is accepted and lands at the tail.
    OUT_READY = 1'b1;
    store(32'h0010_00F0, 32'h0000_00AA, 4'h5);
    void'(exp_addr_q.pop_front());
    void'(exp_data_q.pop_front());
    exp_addr_q.push_back(32'h0010_00F0);
    exp_data_q.push_back(32'h0000_00AA);
    chk("fullpop_level", 32'(LEVEL), 32'd16);
    chk("fullpop_drop",  32'(DROP_CNT), 32'd2);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(OUT_VALID), 32'd1);
      chk($sformatf("drain%0d_addr", i),  OUT_ADDR, exp_addr_q[i]);
      chk($sformatf("drain%0d_data", i),  OUT_DATA, exp_data_q[i]);
      step();
    end
    chk("drain_empty", 32'(OUT_VALID), 32'd0);
    chk("drain_level", 32'(LEVEL), 32'd0);

    // Halt: fetch of the ebreak while three stores wait behind a stalled consumer.
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h0010_0100 + 32'(i * 4), 32'(i), 4'hF);
    chk("halt_q_level", 32'(LEVEL), 32'd3);
    PC = 32'h0000_0064;
    step();
    PC = 32'h0;
    chk("halt_seen", 32'(HALT), 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("halt_stalled", 32'(HALT), 32'd0);
    chk("halt_stalled_level", 32'(LEVEL), 32'd3);
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("halt_pop%0d", i), 32'(HALT), 32'd0);
    end
    chk("halt_drained", 32'(LEVEL), 32'd0);
    step();
    chk("halt_set", 32'(HALT), 32'd1);
    PC = 32'h0000_0064;
    store(32'h0010_0200, 32'h5555_5555, 4'hF);
    PC = 32'h0;
    chk("halt_ign_valid", 32'(OUT_VALID), 32'd0);
    chk("halt_ign_level", 32'(LEVEL), 32'd0);
    chk("halt_ign_drop",  32'(DROP_CNT), 32'd2);
    chk("halt_sticky",    32'(HALT), 32'd1);

    // Reset mid-drain: queued entries must vanish.
    RST = 1'b1; step(); RST = 1'b0;
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) store(32'h0010_0300 + 32'(i * 4), 32'hB0 + 32'(i), 4'hF);
    chk("mid_level", 32'(LEVEL), 32'd5);
    chk("mid_head",  OUT_ADDR, 32'h0010_0300);
    OUT_READY = 1'b1;
    RST = 1'b1; step(); RST = 1'b0;
    chk("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    chk("mid_rst_level", 32'(LEVEL), 32'd0);
    chk("mid_rst_drop",  32'(DROP_CNT), 32'd0);
    chk("mid_rst_halt",  32'(HALT), 32'd0);
    chk("mid_rst_addr",  OUT_ADDR, 32'd0);
`ifdef DBG_MON_TIMESTAMP_EN
    chk("mid_rst_time",  OUT_TIME, 32'd0);
`endif
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("post_rst_valid%0d", i), 32'(OUT_VALID), 32'd0);
    end
    OUT_READY = 1'b0;
    store(32'h0010_0400, 32'hCAFE_F00D, 4'h8);
    chk("post_rst_store_valid", 32'(OUT_VALID), 32'd1);
    chk("post_rst_store_data",  OUT_DATA, 32'hCAFE_F00D);
`ifdef DBG_MON_TIMESTAMP_EN
    // Counter was 0 after the reset edge and the store lands on the third edge after it.
    chk("post_rst_time", OUT_TIME, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_store_monitor.md
Name: dbg_store_monitor

Overview:
Sits beside the pipeline core's data-memory port and the fetch PC.
- Captures stores into the memory-mapped debug region (byte address [31:20] == 12'h001).
- Buffers each captured store in a FIFO and drains it to a consumer (bench printer or UART bridge) over valid/ready.
- Raises a sticky HALT once the core has fetched the terminating ebreak address and all captured stores have drained.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
REGION, 12'h001, value matched against ST_ADDR[31:20].
HALT_PC, 32'h00000064, fetch address of the final ebreak.
GUARD, 4, cycles to keep capturing after HALT_PC is seen, so in-flight pipeline stores are not lost.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- PC  in  32  fetch-stage PC (PC_IF).
- ST_EN  in  1  store strobe from the core, one cycle per store.
- ST_ADDR  in  32  store byte address.
- ST_DATA  in  32  store data, pre-alignment.
- ST_BE  in  4  byte enables.
- OUT_VALID  out  1  FIFO head entry is valid.
- OUT_READY  in  1  consumer accepts the head entry.
- OUT_ADDR  out  32  head entry address.
- OUT_DATA  out  32  head entry data.
- OUT_BE  out  4  head entry byte enables.
- LEVEL  out  $clog2(DEPTH)+1  current occupancy.
- DROP_CNT  out  16  count of stores lost to a full FIFO; saturates at 16'hFFFF.
- HALT  out  1  sticky end-of-run flag.

Behaviour:
- Reset (RST=1 at a rising edge): FIFO emptied; state=RUN; guard counter=0.
  - Outputs after reset: OUT_VALID=0, OUT_ADDR/OUT_DATA/OUT_BE=0, LEVEL=0, DROP_CNT=0, HALT=0.
  - RST asserted mid-drain discards all entries; nothing is output afterwards.
- match = ST_EN && ST_ADDR[31:20]==REGION && state!=HALTED.
- pop = OUT_VALID && OUT_READY.
- push = match && (LEVEL<DEPTH || pop).
  - When full, a simultaneous pop frees a slot, so the store is accepted.
  - match && !push increments DROP_CNT (saturating); the FIFO is unchanged.
- Latency: a store pushed at edge N is visible at the head (OUT_VALID=1) in the cycle after N, if the FIFO was empty. Head outputs are registered/first-word-fall-through. OUT_* are held stable while OUT_VALID && !OUT_READY.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- LEVEL update: +1 on push only, -1 on pop only, unchanged on both or neither.
- OUT_* are 0 when empty.
- FSM (state):
  - RUN: PC==HALT_PC → DRAIN, guard counter loaded with GUARD.
  - DRAIN: capture continues. Guard counter decrements to 0. When guard==0 && LEVEL==0 && !push → HALTED.
  - HALTED: HALT=1; ST_EN ignored (not counted as drops); leaves only on RST.
  - PC==HALT_PC seen again in DRAIN or HALTED has no effect.
- HALT asserts in the cycle after the HALTED transition edge.

Optional Feature:
DBG_MON_TIMESTAMP_EN
- Defined:
  - Adds a free-running 32-bit cycle counter, cleared by RST and wrapping at 2^32.
  - Adds output port OUT_TIME (32 bits): the counter value at the push edge, stored per entry.
  - OUT_TIME is 0 when empty.
- Undefined: no counter, no OUT_TIME port, no per-entry time storage. All other behaviour is identical.

Decomposition:
- Shared package dbg_mon_pkg holds:
  - state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2);
  - default REGION and HALT_PC constants;
  - entry layout: {addr[31:0], data[31:0], be[3:0]}, plus time[31:0] under the macro.
- One sub-module: dbg_sync_fifo. It is parameterised by width and depth, has push/pop/full/empty/level, and is reusable.
- The FSM, match logic and drop counter live in the top.

Test Plan:
- Single store: ST_EN=1, ST_ADDR=32'h00100004, ST_DATA=32'hDEADBEEF, ST_BE=4'hF with OUT_READY=1 → next cycle OUT_VALID=1, OUT_ADDR=32'h00100004, OUT_DATA=32'hDEADBEEF; then OUT_VALID=0, LEVEL=0.
- Filter: store to 32'h00200000 → never output, DROP_CNT stays 0.
- Overflow: OUT_READY=0, 18 region stores with DEPTH=16 → LEVEL=16, DROP_CNT=2. Draining gives the first 16 in order.
- Full plus simultaneous pop: LEVEL=16, OUT_READY=1 with a new store in the same cycle → LEVEL stays 16, DROP_CNT unchanged, new entry comes out last.
- Halt: three queued stores, OUT_READY=0, PC=32'h00000064 → HALT stays 0. Release OUT_READY → HALT=1 one cycle after the last pop, provided GUARD has expired. A store after HALT is ignored.
- Reset mid-drain: LEVEL=5, RST pulsed for one cycle → OUT_VALID=0, LEVEL=0, DROP_CNT=0, HALT=0. With the macro defined, OUT_TIME restarts from 0.
